// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_e;

endpackage

// File: rtl/decoder_7_seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {a,b,c,d,e,f,g}.
module decoder_7_seg (
  input  logic [3:0] n,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (n)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with blanking gaps between digits.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);

  localparam int unsigned CntMax = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);

  scan_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] val_sh_q, val_sh_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [DIGITS-1:0]   mask_sh_q, mask_sh_d;
  logic                load;
  logic [DIGITS-1:0]   lzb;

  logic [3:0]          nib;
  logic                dp_bit, mask_bit, lit;
  logic [6:0]          dec_seg;
  logic [6:0]          seg_n_d;
  logic                dp_n_d, frame_tick_d;
  logic [DIGITS-1:0]   an_n_d;

`ifdef SEG_SCAN_LZB_EN
  logic nz;
  always_comb begin
    lzb = '0;
    nz  = 1'b0;
    // Digit 0 is never zero-blanked, so a value of 0 still shows one "0".
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      nz = nz | (value[4*i +: 4] != 4'h0);
      if (!nz) lzb[i] = 1'b1;
    end
  end
`else
  always_comb lzb = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CntW'(1);
    load    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BlankLast) begin
            state_d = SHOW;
            cnt_d   = '0;
          end
        end
        SHOW: begin
          if (cnt_q == DwellLast) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IdxLast) begin
              idx_d = '0;
              load  = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign val_sh_d  = load ? value : val_sh_q;
  assign dp_sh_d   = load ? dp : dp_sh_q;
  assign mask_sh_d = load ? (blank_mask | lzb) : mask_sh_q;

  // Outputs are derived from next-state values so the registered pins track state exactly.
  always_comb begin
    nib      = 4'h0;
    dp_bit   = 1'b0;
    mask_bit = 1'b0;
    an_n_d   = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IdxW'(i) == idx_d) begin
        nib      = val_sh_d[4*i +: 4];
        dp_bit   = dp_sh_d[i];
        mask_bit = mask_sh_d[i];
        if (state_d == SHOW) an_n_d[i] = 1'b0;
      end
    end
    lit          = (state_d != IDLE) && !mask_bit;
    seg_n_d      = lit ? dec_seg : SEG_OFF;
    dp_n_d       = !(lit && dp_bit);
    frame_tick_d = (state_d == SHOW) && (cnt_d == DwellLast) && (idx_d == IdxLast);
  end

  decoder_7_seg u_dec (
    .n   (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      val_sh_q   <= '0;
      dp_sh_q    <= '0;
      mask_sh_q  <= '0;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      val_sh_q   <= val_sh_d;
      dp_sh_q    <= dp_sh_d;
      mask_sh_q  <= mask_sh_d;
      seg_n      <= seg_n_d;
      dp_n       <= dp_n_d;
      an_n       <= an_n_d;
      frame_tick <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position model plus directed literal checks.
// Honours SEG_SCAN_LZB_EN the same way as the design.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DWELL  = 8;
  localparam int unsigned BLANKC = 2;
  localparam int unsigned SLOT   = DWELL + BLANKC;
  localparam int unsigned FRAME  = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANKC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .value      (value),
    .dp         (dp),
    .blank_mask (blank_mask),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [3:0] eff_mask(input logic [15:0] v, input logic [3:0] bm);
    logic [3:0] m;
    m = bm;
`ifdef SEG_SCAN_LZB_EN
    for (int i = 1; i < 4; i++) if ((v >> (4 * i)) == 16'h0) m[i] = 1'b1;
`endif
    return m;
  endfunction

  // Model: position within the frame since the scan started, plus the frame's captured inputs.
  logic        m_active;
  int unsigned m_p;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_mask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !en) begin
      m_active <= 1'b0;
      m_p      <= 0;
    end else if (!m_active || m_p == FRAME - 1) begin
      m_active <= 1'b1;
      m_p      <= 0;
      m_val    <= value;
      m_dp     <= dp;
      m_mask   <= eff_mask(value, blank_mask);
    end else begin
      m_p <= m_p + 1;
    end
  end

  // {an_n, seg_n, dp_n, frame_tick}
  function automatic logic [12:0] model_out();
    int unsigned slot;
    logic show, lit;
    logic [3:0] an;
    logic [6:0] sg;
    if (!m_active) return {4'hF, 7'h7F, 1'b1, 1'b0};
    slot = m_p / SLOT;
    show = (m_p % SLOT) >= BLANKC;
    lit  = !m_mask[slot];
    an   = show ? ~(4'b0001 << slot) : 4'hF;
    sg   = lit ? hex7(m_val[4*slot +: 4]) : 7'h7F;
    return {an, sg, !(lit && m_dp[slot]), (m_p == FRAME - 1)};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      logic [12:0] exp_v;
      exp_v = model_out();
      checks++;
      if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t: an_n=%b seg_n=%b dp_n=%b tick=%b, expected an_n=%b seg_n=%b dp_n=%b tick=%b",
                 $time, an_n, seg_n, dp_n, frame_tick,
                 exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (an_n === target) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_an: an_n=%b, expected %b within %0d cycles", an_n, target, budget);
  endtask

  task automatic wait_tick(input int budget, output int waited);
    waited = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        waited = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_tick: frame_tick=0, expected a pulse within %0d cycles", budget);
  endtask

  initial begin
    int w;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_an_n", {12'h0, an_n}, 16'h000F);
    chk("reset_seg_n", {9'h0, seg_n}, 16'h007F);
    chk("reset_dp_n_tick", {14'h0, dp_n, frame_tick}, 16'h0002);
    #1 rst_n = 1'b1;

    // 1: basic scan of 1234
    @(negedge clk);
    value = 16'h1234;
    en    = 1'b1;
    @(negedge clk);
    chk("first_blank_an", {12'h0, an_n}, 16'h000F);
    wait_an(4'b1110, 10);
    chk("digit0_seg_4", {9'h0, seg_n}, {9'h0, 7'b1001100});
    wait_tick(100, w);
    wait_tick(100, w);
    chk("frame_period", 16'(w), 16'd40);

    // 2: mid-frame value change is deferred to the next frame
    repeat (5) @(negedge clk);
    value = 16'hABCD;
    wait_an(4'b0111, 60);
    chk("old_frame_digit3_1", {9'h0, seg_n}, {9'h0, 7'b1001111});
    wait_an(4'b1110, 60);
    chk("new_frame_digit0_D", {9'h0, seg_n}, {9'h0, 7'b1000010});

    // 3: blank mask and decimal point
    blank_mask = 4'b0100;
    dp         = 4'b0001;
    wait_tick(100, w);
    wait_an(4'b1110, 20);
    chk("dp_digit0_lit", {15'h0, dp_n}, 16'h0000);
    wait_an(4'b1101, 20);
    chk("dp_digit1_dark", {15'h0, dp_n}, 16'h0001);
    wait_an(4'b1011, 20);
    chk("masked_digit2_seg", {9'h0, seg_n}, 16'h007F);

    // 4: drop enable during digit 2 SHOW, then restart
    en = 1'b0;
    @(negedge clk);
    chk("en_off_an", {12'h0, an_n}, 16'h000F);
    chk("en_off_seg", {9'h0, seg_n}, 16'h007F);
    en = 1'b1;
    wait_an(4'b1110, 5);
    chk("restart_seg_D", {9'h0, seg_n}, {9'h0, 7'b1000010});

    // 5: asynchronous reset in the BLANK before digit 2
    wait_an(4'b1101, 20);
    wait_an(4'b1111, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {12'h0, an_n}, 16'h000F);
    chk("async_rst_seg", {9'h0, seg_n}, 16'h007F);
    chk("async_rst_dp_tick", {14'h0, dp_n, frame_tick}, 16'h0002);
    @(negedge clk);
    chk("rst_hold_tick", {15'h0, frame_tick}, 16'h0000);
    #1 rst_n = 1'b1;

    // 6: leading zeros
    blank_mask = 4'b0000;
    dp         = 4'b0000;
    value      = 16'h0040;
    wait_tick(100, w);
    wait_an(4'b1110, 20);
    chk("v0040_digit0", {9'h0, seg_n}, {9'h0, 7'b0000001});
    wait_an(4'b1101, 20);
    chk("v0040_digit1", {9'h0, seg_n}, {9'h0, 7'b1001100});
    wait_an(4'b0111, 40);
`ifdef SEG_SCAN_LZB_EN
    chk("v0040_digit3_lzb", {9'h0, seg_n}, 16'h007F);
    value = 16'h0000;
    wait_tick(100, w);
    wait_an(4'b1101, 30);
    chk("v0000_digit1_lzb", {9'h0, seg_n}, 16'h007F);
    wait_an(4'b1110, 40);
    chk("v0000_digit0", {9'h0, seg_n}, {9'h0, 7'b0000001});
`else
    chk("v0040_digit3_zero", {9'h0, seg_n}, {9'h0, 7'b0000001});
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
